// File: rtl/audio_i2s_rx.sv
// I2S master receiver: generates adc_bclk/adc_lrc from osc_clk, deserialises both slots and offers sample pairs.
// Build option: define AUDIO_I2S_RX_LJ_EN for left-justified slot timing (default is standard I2S, MSB one bit late).
module audio_i2s_rx #(
    parameter int DATA_W   = 16,
    parameter int BCLK_DIV = 8
) (
    input  logic              osc_clk,
    input  logic              reset_n,
    input  logic              en,
    output logic              adc_bclk,
    output logic              adc_lrc,
    input  logic              adc_dat,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam int DIV_W = $clog2(BCLK_DIV);
`ifdef AUDIO_I2S_RX_LJ_EN
    localparam int FIRST_BIT = 0;
`else
    localparam int FIRST_BIT = 1;
`endif
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [4:0]       FIRST_IDX = 5'(FIRST_BIT);
    localparam logic [4:0]       LAST_IDX  = 5'(FIRST_BIT + DATA_W - 1);
    localparam logic [4:0]       SLOT_W    = 5'(DATA_W);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              bclk_q, bclk_d;
    logic              lrc_q, lrc_d;
    logic [4:0]        bit_q, bit_d;
    logic [DATA_W-1:0] left_sr_q, left_sr_d;
    logic [DATA_W-1:0] right_sr_q, right_sr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] left_data_q, left_data_d;
    logic [DATA_W-1:0] right_data_q, right_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              in_window;

    // Subtracting FIRST_IDX wraps slot bit 0 to 31 in I2S mode, so one compare covers the data window.
    assign in_window = ((bit_q - FIRST_IDX) < SLOT_W);

    always_comb begin
        div_d        = div_q;
        bclk_d       = bclk_q;
        lrc_d        = lrc_q;
        bit_d        = bit_q;
        left_sr_d    = left_sr_q;
        right_sr_d   = right_sr_q;
        done_d       = 1'b0;
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        out_valid_d  = out_valid_q;
        overrun_d    = 1'b0;

        if (!en) begin
            div_d      = '0;
            bclk_d     = 1'b0;
            lrc_d      = 1'b0;
            bit_d      = '0;
            left_sr_d  = '0;
            right_sr_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            if (!bclk_q) begin
                if (in_window) begin
                    if (lrc_q) begin
                        right_sr_d = {right_sr_q[DATA_W-2:0], adc_dat};
                    end else begin
                        left_sr_d = {left_sr_q[DATA_W-2:0], adc_dat};
                    end
                end
                done_d = lrc_q && (bit_q == LAST_IDX);
                bit_d  = bit_q + 5'd1;
            end else if (bit_q == 5'd0) begin
                // Falling edge after bit 31 of a slot opens the other slot.
                lrc_d = ~lrc_q;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (done_q && en) begin
            if (!out_valid_q || out_ready) begin
                left_data_d  = left_sr_q;
                right_data_d = right_sr_q;
                out_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            lrc_q        <= 1'b0;
            bit_q        <= '0;
            left_sr_q    <= '0;
            right_sr_q   <= '0;
            done_q       <= 1'b0;
            left_data_q  <= '0;
            right_data_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            lrc_q        <= lrc_d;
            bit_q        <= bit_d;
            left_sr_q    <= left_sr_d;
            right_sr_q   <= right_sr_d;
            done_q       <= done_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign adc_bclk   = bclk_q;
    assign adc_lrc    = lrc_q;
    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Self-checking bench for audio_i2s_rx: a codec model serialises per-frame sample pairs with random filler bits,
// and expected pairs/timing come from frame arithmetic (64 bit clocks per frame, data window set by the justification).
`timescale 1ns/1ps
module tb_audio_i2s_rx;

    localparam int DATA_W   = 16;
    localparam int BCLK_DIV = 8;
    localparam int PERIOD   = 2 * BCLK_DIV;
`ifdef AUDIO_I2S_RX_LJ_EN
    localparam int FIRST_BIT = 0;
`else
    localparam int FIRST_BIT = 1;
`endif

    logic              osc_clk;
    logic              reset_n;
    logic              en;
    logic              adc_bclk;
    logic              adc_lrc;
    logic              adc_dat;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;

    audio_i2s_rx #(.DATA_W(DATA_W), .BCLK_DIV(BCLK_DIV)) dut (
        .osc_clk   (osc_clk),
        .reset_n   (reset_n),
        .en        (en),
        .adc_bclk  (adc_bclk),
        .adc_lrc   (adc_lrc),
        .adc_dat   (adc_dat),
        .left_data (left_data),
        .right_data(right_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;
    int validHighCycles = 0;
    int overrunCount = 0;
    logic [DATA_W-1:0] accL[$];
    logic [DATA_W-1:0] accR[$];
    logic [DATA_W-1:0] frameL[8];
    logic [DATA_W-1:0] frameR[8];

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk) cycleCount <= cycleCount + 1;

    // Records every accepted pair and every cycle of out_valid/overrun for later comparison.
    always @(negedge osc_clk) begin
        if (reset_n) begin
            if (out_valid) validHighCycles <= validHighCycles + 1;
            if (overrun) overrunCount <= overrunCount + 1;
            if (out_valid && out_ready) begin
                accL.push_back(left_data);
                accR.push_back(right_data);
            end
        end
    end

    // Osc edge at which frame k (counted from enable) is offered: first rising edge after BCLK_DIV cycles,
    // frame completes on right slot bit FIRST_BIT+DATA_W-1, offer one cycle later.
    function automatic int loadEdge(input int k);
        return BCLK_DIV + PERIOD * (64 * k + 32 + FIRST_BIT + DATA_W - 1) + 1;
    endfunction

    // Bit the codec presents for the n-th rising edge since enable; bits outside the data window are random.
    function automatic logic codecBit(input int n);
        int frame;
        int pos;
        logic [DATA_W-1:0] word;
        frame = (n / 64) % 8;
        word  = ((n % 64) >= 32) ? frameR[frame] : frameL[frame];
        pos   = (n % 32) - FIRST_BIT;
        if (pos >= 0 && pos < DATA_W) return word[DATA_W-1-pos];
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] accAt(input int idx, input bit rightCh);
        if (idx >= accL.size()) return 'x;
        return rightCh ? 32'(accR[idx]) : 32'(accL[idx]);
    endfunction

    // Codec: counts adc_bclk rising edges since enable and updates its data line shortly after each osc edge.
    initial begin
        int riseCount;
        logic bclkPrev;
        riseCount = 0;
        bclkPrev  = 1'b0;
        adc_dat   = 1'b0;
        forever begin
            @(posedge osc_clk);
            #2;
            if (!reset_n || !en) begin
                riseCount = 0;
                bclkPrev  = 1'b0;
            end else begin
                if (adc_bclk && !bclkPrev) riseCount++;
                bclkPrev = adc_bclk;
            end
            adc_dat = codecBit(riseCount);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enVal, input logic readyVal);
        @(negedge osc_clk);
        en        = enVal;
        out_ready = readyVal;
    endtask

    task automatic waitBclk(input logic level, input int budget);
        int n = 0;
        while (adc_bclk !== level && n < budget) begin
            @(negedge osc_clk);
            n++;
        end
    endtask

    task automatic waitLrc(input logic level, input int budget);
        int n = 0;
        while (adc_lrc !== level && n < budget) begin
            @(negedge osc_clk);
            n++;
        end
    endtask

    task automatic waitAcc(input int target, input int budget);
        int n = 0;
        while (accL.size() < target && n < budget) begin
            @(negedge osc_clk);
            n++;
        end
    endtask

    task automatic waitUntil(input int t0, input int offset);
        while (cycleCount - t0 < offset) @(negedge osc_clk);
    endtask

    initial begin
        int t0;
        int tRise;
        int accBase;
        int vBase;
        int ovBase;
        int bad;
        int vSeen;

        reset_n   = 1'b0;
        en        = 1'b0;
        out_ready = 1'b1;
        frameL[0] = 16'h8001;
        frameR[0] = 16'h7FFE;
        for (int i = 1; i < 8; i++) begin
            frameL[i] = DATA_W'($urandom);
            frameR[i] = DATA_W'($urandom);
        end

        repeat (3) @(negedge osc_clk);
        checkOutput("reset_bclk", 32'(adc_bclk), 32'd0);
        checkOutput("reset_lrc", 32'(adc_lrc), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_left", 32'(left_data), 32'd0);
        checkOutput("reset_right", 32'(right_data), 32'd0);

        // Clock generation and fixed-pattern capture with a consumer that is always ready.
        @(negedge osc_clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1);
        t0 = cycleCount;
        waitBclk(1'b1, 100);
        checkOutput("first_rise", 32'(cycleCount - t0), 32'(BCLK_DIV));
        tRise = cycleCount;
        waitBclk(1'b0, 100);
        waitBclk(1'b1, 100);
        checkOutput("bclk_period", 32'(cycleCount - tRise), 32'(PERIOD));
        waitLrc(1'b1, 2000);
        checkOutput("lrc_low_len", 32'(cycleCount - t0), 32'(32 * PERIOD));
        waitLrc(1'b0, 2000);
        checkOutput("lrc_period", 32'(cycleCount - t0), 32'(64 * PERIOD));
        waitAcc(3, 4000);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("pairA%0d_left", i), accAt(i, 1'b0), 32'(frameL[i]));
            checkOutput($sformatf("pairA%0d_right", i), accAt(i, 1'b1), 32'(frameR[i]));
        end
        checkOutput("pulse_cycles", 32'(validHighCycles), 32'd3);
        checkOutput("no_overrun_A", 32'(overrunCount), 32'd0);

        // Back-pressure: second frame dropped, third loads on the exact cycle the held pair is accepted.
        applyStimulus(1'b0, 1'b0);
        frameL[0] = 16'h1234;
        frameR[0] = 16'h5678;
        frameL[1] = 16'hAAAA;
        frameR[1] = 16'h5555;
        ovBase = overrunCount;
        applyStimulus(1'b1, 1'b0);
        t0 = cycleCount;
        waitUntil(t0, loadEdge(0));
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_left", 32'(left_data), 32'h1234);
        checkOutput("hold_right", 32'(right_data), 32'h5678);
        waitUntil(t0, loadEdge(1) + 2);
        checkOutput("drop_valid", 32'(out_valid), 32'd1);
        checkOutput("drop_left", 32'(left_data), 32'h1234);
        checkOutput("drop_right", 32'(right_data), 32'h5678);
        checkOutput("overrun_once", 32'(overrunCount - ovBase), 32'd1);
        waitUntil(t0, loadEdge(2) - 1);
        out_ready = 1'b1;
        @(negedge osc_clk);
        checkOutput("reload_valid", 32'(out_valid), 32'd1);
        checkOutput("reload_left", 32'(left_data), 32'(frameL[2]));
        checkOutput("reload_right", 32'(right_data), 32'(frameR[2]));
        checkOutput("reload_no_ovr", 32'(overrun), 32'd0);
        @(negedge osc_clk);
        checkOutput("valid_clears", 32'(out_valid), 32'd0);

        // Enable dropped in the middle of the left slot, then raised again.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            frameL[i] = DATA_W'($urandom);
            frameR[i] = DATA_W'($urandom);
        end
        vBase = validHighCycles;
        applyStimulus(1'b1, 1'b1);
        t0 = cycleCount;
        waitUntil(t0, BCLK_DIV + PERIOD * 10);
        applyStimulus(1'b0, 1'b1);
        bad   = 0;
        vSeen = 0;
        repeat (60) begin
            @(negedge osc_clk);
            if (adc_bclk !== 1'b0 || adc_lrc !== 1'b0) bad++;
            if (out_valid) vSeen++;
        end
        checkOutput("idle_clocks_low", 32'(bad), 32'd0);
        checkOutput("idle_no_valid", 32'(vSeen), 32'd0);
        frameL[0] = DATA_W'($urandom);
        frameR[0] = DATA_W'($urandom);
        accBase = accL.size();
        applyStimulus(1'b1, 1'b1);
        t0 = cycleCount;
        waitUntil(t0, loadEdge(0) + 1);
        checkOutput("reen_count", 32'(accL.size() - accBase), 32'd1);
        checkOutput("reen_left", accAt(accBase, 1'b0), 32'(frameL[0]));
        checkOutput("reen_right", accAt(accBase, 1'b1), 32'(frameR[0]));
        checkOutput("reen_pulses", 32'(validHighCycles - vBase), 32'd1);

        // Random frames streamed back to back.
        waitAcc(accBase + 4, 5000);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("rand%0d_left", i), accAt(accBase + i, 1'b0), 32'(frameL[i]));
            checkOutput($sformatf("rand%0d_right", i), accAt(accBase + i, 1'b1), 32'(frameR[i]));
        end

        // Asynchronous reset while adc_bclk is high, then restart from a fresh left slot.
        waitBclk(1'b1, 100);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_bclk", 32'(adc_bclk), 32'd0);
        checkOutput("async_left", 32'(left_data), 32'd0);
        checkOutput("async_right", 32'(right_data), 32'd0);
        accBase = accL.size();
        @(negedge osc_clk);
        reset_n = 1'b1;
        t0 = cycleCount;
        waitBclk(1'b1, 100);
        checkOutput("rst_first_rise", 32'(cycleCount - t0), 32'(BCLK_DIV));
        checkOutput("rst_lrc_left", 32'(adc_lrc), 32'd0);
        waitAcc(accBase + 1, 1200);
        checkOutput("rst_left", accAt(accBase, 1'b0), 32'(frameL[0]));
        checkOutput("rst_right", accAt(accBase, 1'b1), 32'(frameR[0]));
        checkOutput("overrun_total", 32'(overrunCount), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
